sub_div_seq: RTL

SUB_DIV_SEQ -- requirements
Module: sub_div_seq

---
 rtl/sub_div_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sub_div_seq.sv
// Sequential 4-bit unsigned restoring divider. Each ITER cycle makes one trial
// subtraction through an external combinational subtractor stage.
module sub_div_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_zero,
    output logic [3:0] sub_a,
    output logic [3:0] sub_b,
    output logic       sub_c_in,
    input  logic [3:0] sub_s,
    input  logic       sub_c_out,
    output logic [1:0] state_dbg
);

    // Handshake: start is a request pulse that is taken on a rising clk edge
    // only while idle or done; it is ignored while busy. done is a one-cycle
    // pulse, and the results stay valid until the next accepted start.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] r_q;
    logic [3:0] a_q;
    logic [3:0] d_q;
    logic [1:0] count_q;
    logic       load;
    logic [4:0] t;
    logic       accept;
    logic [3:0] r_next;
    logic [3:0] a_next;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (divisor == 4'd0) ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (count_q == 2'd0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = (divisor == 4'd0) ? S_DONE : S_ITER;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // T[4] set means the shifted partial remainder already exceeds any 4-bit
    // divisor, so the trial subtraction is accepted regardless of borrow.
    always_comb begin
        t        = {r_q, a_q[3]};
        sub_a    = busy ? t[3:0] : 4'd0;
        sub_b    = busy ? d_q : 4'd0;
        sub_c_in = 1'b0;
        accept   = t[4] | ~sub_c_out;
        r_next   = accept ? sub_s : t[3:0];
        a_next   = {a_q[2:0], accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= 4'd0;
            a_q       <= 4'd0;
            d_q       <= 4'd0;
            count_q   <= 2'd0;
            quotient  <= 4'd0;
            remainder <= 4'd0;
            div_zero  <= 1'b0;
        end else if (load) begin
            r_q     <= 4'd0;
            a_q     <= dividend;
            d_q     <= divisor;
            count_q <= 2'd3;
            if (divisor == 4'd0) begin
                quotient  <= 4'hF;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end else begin
                div_zero  <= 1'b0;
            end
        end else if (busy) begin
            r_q     <= r_next;
            a_q     <= a_next;
            count_q <= count_q - 2'd1;
            if (count_q == 2'd0) begin
                quotient  <= a_next;
                remainder <= r_next;
            end
        end
    end

endmodule
